// File: rtl/soc_pkg.sv
// Shared arbiter types: controller state encoding and requester identifiers.
package soc_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_WAIT_IFU,
      ARB_WAIT_LSU
   } arb_state_t;

   typedef enum logic {
      ARB_ID_IFU,
      ARB_ID_LSU
   } arb_id_t;

endpackage

// File: rtl/arb_req_slot.sv
// One pending-request register for a single requester.
// Holds a request that could not be issued when it arrived. Clear wins over
// capture so the arbiter can retire the slot in the cycle it issues from it.
module arb_req_slot #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            capture,
   input  logic            clear,
   input  logic [AW-1:0]   in_addr,
   input  logic            in_wen,
   input  logic [DW-1:0]   in_wdata,
   input  logic [DW/8-1:0] in_wmask,
   output logic            valid,
   output logic [AW-1:0]   addr,
   output logic            wen,
   output logic [DW-1:0]   wdata,
   output logic [DW/8-1:0] wmask
);

   // Slot occupancy and payload; payload only loads when the slot fills.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid <= 1'b0;
         addr  <= '0;
         wen   <= 1'b0;
         wdata <= '0;
         wmask <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (capture) begin
         valid <= 1'b1;
         addr  <= in_addr;
         wen   <= in_wen;
         wdata <= in_wdata;
         wmask <= in_wmask;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Memory port arbiter between the instruction fetch unit and load/store unit.
// One transaction is outstanding at memory at a time; each requester may have
// one more request parked in its pending slot. Live requests in an idle cycle
// are bypassed straight to memory with no added latency.
// Optional build macro MEM_ARB_RR_EN: round-robin arbitration when both
// requesters compete; without it the LSU always wins.
module mem_arbiter
   import soc_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            ifu_reqValid,
   input  logic [AW-1:0]   ifu_addr,
   output logic            ifu_respValid,
   output logic [DW-1:0]   ifu_rdata,
   input  logic            lsu_reqValid,
   input  logic [AW-1:0]   lsu_addr,
   input  logic            lsu_wen,
   input  logic [DW-1:0]   lsu_wdata,
   input  logic [DW/8-1:0] lsu_wmask,
   output logic            lsu_respValid,
   output logic [DW-1:0]   lsu_rdata,
   output logic            mem_reqValid,
   output logic [AW-1:0]   mem_addr,
   output logic            mem_wen,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_wmask,
   input  logic            mem_respValid,
   input  logic [DW-1:0]   mem_rdata
);

   localparam int MW = DW / 8;

   arb_state_t state, state_next;

   logic          ifu_slot_valid;
   logic [AW-1:0] ifu_slot_addr;
   logic          ifu_slot_wen;
   logic [DW-1:0] ifu_slot_wdata;
   logic [MW-1:0] ifu_slot_wmask;
   logic          ifu_capture, ifu_clear;

   logic          lsu_slot_valid;
   logic [AW-1:0] lsu_slot_addr;
   logic          lsu_slot_wen;
   logic [DW-1:0] lsu_slot_wdata;
   logic [MW-1:0] lsu_slot_wmask;
   logic          lsu_capture, lsu_clear;

   logic ifu_cand, lsu_cand;
   logic issue;
   logic grant_lsu;
   logic ifu_live_issued, lsu_live_issued;
   logic ifu_owner_busy, lsu_owner_busy;

   // Pending slot for fetches; fetches never write, so write fields stay 0.
   arb_req_slot #(.AW(AW), .DW(DW)) u_ifu_slot (
      .clock    (clock),
      .reset    (reset),
      .capture  (ifu_capture),
      .clear    (ifu_clear),
      .in_addr  (ifu_addr),
      .in_wen   (1'b0),
      .in_wdata ('0),
      .in_wmask ('0),
      .valid    (ifu_slot_valid),
      .addr     (ifu_slot_addr),
      .wen      (ifu_slot_wen),
      .wdata    (ifu_slot_wdata),
      .wmask    (ifu_slot_wmask)
   );

   // Pending slot for loads and stores.
   arb_req_slot #(.AW(AW), .DW(DW)) u_lsu_slot (
      .clock    (clock),
      .reset    (reset),
      .capture  (lsu_capture),
      .clear    (lsu_clear),
      .in_addr  (lsu_addr),
      .in_wen   (lsu_wen),
      .in_wdata (lsu_wdata),
      .in_wmask (lsu_wmask),
      .valid    (lsu_slot_valid),
      .addr     (lsu_slot_addr),
      .wen      (lsu_slot_wen),
      .wdata    (lsu_slot_wdata),
      .wmask    (lsu_slot_wmask)
   );

   // A requester is a candidate if it has a parked request or a live one.
   // With a full slot the parked request is the candidate and any live
   // pulse is a protocol violation that gets dropped.
   assign ifu_cand = ifu_slot_valid | ifu_reqValid;
   assign lsu_cand = lsu_slot_valid | lsu_reqValid;

   // Issue only from idle; reset blanks the request output combinationally.
   assign issue = !reset && (state == ARB_IDLE) && (ifu_cand || lsu_cand);

`ifdef MEM_ARB_RR_EN
   arb_id_t last_grant;

   // On contention, favour whichever requester was not served last.
   always_comb begin
      grant_lsu = lsu_cand && (!ifu_cand || (last_grant == ARB_ID_IFU));
   end

   // Remember the most recent winner on every issue.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_grant <= ARB_ID_IFU;
      end else if (issue) begin
         last_grant <= grant_lsu ? ARB_ID_LSU : ARB_ID_IFU;
      end
   end
`else
   // Fixed priority: a load/store always beats a fetch.
   always_comb begin
      grant_lsu = lsu_cand;
   end
`endif

   // A live request consumed directly by the issue path is not parked.
   assign ifu_live_issued = issue && !grant_lsu && !ifu_slot_valid;
   assign lsu_live_issued = issue &&  grant_lsu && !lsu_slot_valid;

   // The owner of the in-flight transaction may not queue another request
   // until its response cycle; in the response cycle ownership is ending,
   // so a new request is parked and issued from the next idle cycle.
   assign ifu_owner_busy = (state == ARB_WAIT_IFU) && !mem_respValid;
   assign lsu_owner_busy = (state == ARB_WAIT_LSU) && !mem_respValid;

   // Park every live request that is neither issued now nor a violation.
   assign ifu_capture = ifu_reqValid && !ifu_slot_valid && !ifu_live_issued && !ifu_owner_busy;
   assign lsu_capture = lsu_reqValid && !lsu_slot_valid && !lsu_live_issued && !lsu_owner_busy;

   // Retire a slot in the cycle its parked request wins.
   assign ifu_clear = issue && !grant_lsu && ifu_slot_valid;
   assign lsu_clear = issue &&  grant_lsu && lsu_slot_valid;

   // Read data is shared; only the respValid pulses say whose it is.
   assign ifu_rdata = mem_rdata;
   assign lsu_rdata = mem_rdata;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state, memory request mux and response routing.
   always_comb begin
      state_next    = state;
      mem_reqValid  = 1'b0;
      mem_addr      = '0;
      mem_wen       = 1'b0;
      mem_wdata     = '0;
      mem_wmask     = '0;
      ifu_respValid = 1'b0;
      lsu_respValid = 1'b0;

      unique case (state)
         ARB_IDLE: begin
            if (issue) begin
               mem_reqValid = 1'b1;
               if (grant_lsu) begin
                  state_next = ARB_WAIT_LSU;
                  if (lsu_slot_valid) begin
                     mem_addr  = lsu_slot_addr;
                     mem_wen   = lsu_slot_wen;
                     mem_wdata = lsu_slot_wdata;
                     mem_wmask = lsu_slot_wen ? lsu_slot_wmask : '0;
                  end else begin
                     mem_addr  = lsu_addr;
                     mem_wen   = lsu_wen;
                     mem_wdata = lsu_wdata;
                     mem_wmask = lsu_wen ? lsu_wmask : '0;
                  end
               end else begin
                  state_next = ARB_WAIT_IFU;
                  if (ifu_slot_valid) begin
                     mem_addr  = ifu_slot_addr;
                     mem_wen   = ifu_slot_wen;
                     mem_wdata = ifu_slot_wdata;
                     mem_wmask = ifu_slot_wmask;
                  end else begin
                     mem_addr  = ifu_addr;
                  end
               end
            end
         end
         ARB_WAIT_IFU: begin
            if (mem_respValid) begin
               ifu_respValid = 1'b1;
               state_next    = ARB_IDLE;
            end
         end
         ARB_WAIT_LSU: begin
            if (mem_respValid) begin
               lsu_respValid = 1'b1;
               state_next    = ARB_IDLE;
            end
         end
         default: begin
            state_next = ARB_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: one task per scenario, inline checks.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clock;
   logic          reset;
   logic          ifu_reqValid;
   logic [AW-1:0] ifu_addr;
   logic          ifu_respValid;
   logic [DW-1:0] ifu_rdata;
   logic          lsu_reqValid;
   logic [AW-1:0] lsu_addr;
   logic          lsu_wen;
   logic [DW-1:0] lsu_wdata;
   logic [3:0]    lsu_wmask;
   logic          lsu_respValid;
   logic [DW-1:0] lsu_rdata;
   logic          mem_reqValid;
   logic [AW-1:0] mem_addr;
   logic          mem_wen;
   logic [DW-1:0] mem_wdata;
   logic [3:0]    mem_wmask;
   logic          mem_respValid;
   logic [DW-1:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clock         (clock),
      .reset         (reset),
      .ifu_reqValid  (ifu_reqValid),
      .ifu_addr      (ifu_addr),
      .ifu_respValid (ifu_respValid),
      .ifu_rdata     (ifu_rdata),
      .lsu_reqValid  (lsu_reqValid),
      .lsu_addr      (lsu_addr),
      .lsu_wen       (lsu_wen),
      .lsu_wdata     (lsu_wdata),
      .lsu_wmask     (lsu_wmask),
      .lsu_respValid (lsu_respValid),
      .lsu_rdata     (lsu_rdata),
      .mem_reqValid  (mem_reqValid),
      .mem_addr      (mem_addr),
      .mem_wen       (mem_wen),
      .mem_wdata     (mem_wdata),
      .mem_wmask     (mem_wmask),
      .mem_respValid (mem_respValid),
      .mem_rdata     (mem_rdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ifu_reqValid = 1'b0; ifu_addr = '0;
      lsu_reqValid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
      mem_respValid = 1'b0; mem_rdata = '0;
      tick(); tick();
      checks++; if (mem_reqValid !== 1'b0) begin errors++; $display("FAIL reset_mem_reqValid got %0b exp 0", mem_reqValid); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
      checks++; if ({ifu_respValid, lsu_respValid} !== 2'b00) begin errors++; $display("FAIL reset_respValid got %b exp 00", {ifu_respValid, lsu_respValid}); end
      reset = 1'b0;
      #1;
      $display("txn reset released");
   endtask

   task automatic test_lone_fetch();
      ifu_reqValid = 1'b1; ifu_addr = 32'h8000_0000;
      #1;
      checks++; if (mem_reqValid !== 1'b1) begin errors++; $display("FAIL lone_issue mem_reqValid got %0b exp 1", mem_reqValid); end
      checks++; if (mem_addr !== 32'h8000_0000) begin errors++; $display("FAIL lone_addr got %h exp 80000000", mem_addr); end
      checks++; if (mem_wen !== 1'b0 || mem_wmask !== 4'h0) begin errors++; $display("FAIL lone_wen got %0b/%h exp 0/0", mem_wen, mem_wmask); end
      tick();
      ifu_reqValid = 1'b0;
      #1;
      checks++; if (mem_reqValid !== 1'b0) begin errors++; $display("FAIL lone_wait1 mem_reqValid got %0b exp 0", mem_reqValid); end
      tick();
      tick();
      mem_respValid = 1'b1; mem_rdata = 32'h0000_0013;
      #1;
      checks++; if (ifu_respValid !== 1'b1) begin errors++; $display("FAIL lone_resp ifu_respValid got %0b exp 1", ifu_respValid); end
      checks++; if (ifu_rdata !== 32'h13) begin errors++; $display("FAIL lone_rdata got %h exp 00000013", ifu_rdata); end
      checks++; if (lsu_respValid !== 1'b0) begin errors++; $display("FAIL lone_lsu_resp got %0b exp 0", lsu_respValid); end
      tick();
      mem_respValid = 1'b0; mem_rdata = '0;
      #1;
      checks++; if (ifu_respValid !== 1'b0) begin errors++; $display("FAIL lone_resp_pulse got %0b exp 0", ifu_respValid); end
      $display("txn lone fetch 80000000 -> 00000013");
   endtask

   task automatic test_simultaneous();
      ifu_reqValid = 1'b1; ifu_addr = 32'h100;
      lsu_reqValid = 1'b1; lsu_addr = 32'h200; lsu_wen = 1'b1; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
      #1;
      checks++; if (mem_reqValid !== 1'b1 || mem_addr !== 32'h200) begin errors++; $display("FAIL sim_lsu_first got %0b/%h exp 1/00000200", mem_reqValid, mem_addr); end
      checks++; if (mem_wen !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_wmask !== 4'hF) begin errors++; $display("FAIL sim_lsu_write got %0b/%h/%h exp 1/deadbeef/f", mem_wen, mem_wdata, mem_wmask); end
      tick();
      ifu_reqValid = 1'b0; lsu_reqValid = 1'b0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
      #1;
      checks++; if (mem_reqValid !== 1'b0) begin errors++; $display("FAIL sim_wait mem_reqValid got %0b exp 0", mem_reqValid); end
      tick();
      mem_respValid = 1'b1;
      #1;
      checks++; if (lsu_respValid !== 1'b1 || ifu_respValid !== 1'b0) begin errors++; $display("FAIL sim_lsu_resp got lsu %0b ifu %0b exp 1 0", lsu_respValid, ifu_respValid); end
      checks++; if (mem_reqValid !== 1'b0) begin errors++; $display("FAIL sim_resp_noreq got %0b exp 0", mem_reqValid); end
      tick();
      mem_respValid = 1'b0;
      #1;
      checks++; if (mem_reqValid !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL sim_ifu_second got %0b/%h exp 1/00000100", mem_reqValid, mem_addr); end
      checks++; if (mem_wen !== 1'b0 || mem_wmask !== 4'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL sim_ifu_read got %0b/%h/%h exp 0/0/0", mem_wen, mem_wmask, mem_wdata); end
      tick();
      mem_respValid = 1'b1; mem_rdata = 32'h0000_0093;
      #1;
      checks++; if (ifu_respValid !== 1'b1 || lsu_respValid !== 1'b0) begin errors++; $display("FAIL sim_ifu_resp got ifu %0b lsu %0b exp 1 0", ifu_respValid, lsu_respValid); end
      tick();
      mem_respValid = 1'b0; mem_rdata = '0;
      $display("txn simultaneous lsu store 200 then ifu fetch 100");
   endtask

   task automatic test_busy();
      ifu_reqValid = 1'b1; ifu_addr = 32'h400;
      #1;
      checks++; if (mem_reqValid !== 1'b1 || mem_addr !== 32'h400) begin errors++; $display("FAIL busy_ifu_issue got %0b/%h exp 1/00000400", mem_reqValid, mem_addr); end
      tick();
      ifu_reqValid = 1'b0;
      tick();
      lsu_reqValid = 1'b1; lsu_addr = 32'h300; lsu_wen = 1'b0;
      #1;
      checks++; if (mem_reqValid !== 1'b0) begin errors++; $display("FAIL busy_no_bypass got %0b exp 0", mem_reqValid); end
      tick();
      lsu_reqValid = 1'b0;
      #1;
      checks++; if (mem_reqValid !== 1'b0) begin errors++; $display("FAIL busy_hold got %0b exp 0", mem_reqValid); end
      tick();
      mem_respValid = 1'b1; mem_rdata = 32'hAAAA_0000;
      #1;
      checks++; if (ifu_respValid !== 1'b1 || mem_reqValid !== 1'b0) begin errors++; $display("FAIL busy_ifu_resp got resp %0b req %0b exp 1 0", ifu_respValid, mem_reqValid); end
      tick();
      mem_respValid = 1'b0; mem_rdata = '0;
      #1;
      checks++; if (mem_reqValid !== 1'b1 || mem_addr !== 32'h300 || mem_wen !== 1'b0) begin errors++; $display("FAIL busy_lsu_issue got %0b/%h/%0b exp 1/00000300/0", mem_reqValid, mem_addr, mem_wen); end
      tick();
      mem_respValid = 1'b1; mem_rdata = 32'h1234_5678;
      #1;
      checks++; if (lsu_respValid !== 1'b1 || lsu_rdata !== 32'h1234_5678) begin errors++; $display("FAIL busy_lsu_resp got %0b/%h exp 1/12345678", lsu_respValid, lsu_rdata); end
      checks++; if (ifu_respValid !== 1'b0) begin errors++; $display("FAIL busy_ifu_quiet got %0b exp 0", ifu_respValid); end
      tick();
      mem_respValid = 1'b0; mem_rdata = '0;
      $display("txn busy: fetch 400 then load 300 -> 12345678");
   endtask

   task automatic test_resp_cycle();
      ifu_reqValid = 1'b1; ifu_addr = 32'h500;
      tick();
      ifu_reqValid = 1'b0;
      tick();
      mem_respValid = 1'b1;
      lsu_reqValid = 1'b1; lsu_addr = 32'h600; lsu_wen = 1'b1; lsu_wdata = 32'h0000_0001; lsu_wmask = 4'h3;
      #1;
      checks++; if (ifu_respValid !== 1'b1) begin errors++; $display("FAIL rc_ifu_resp got %0b exp 1", ifu_respValid); end
      checks++; if (mem_reqValid !== 1'b0) begin errors++; $display("FAIL rc_no_same_cycle got %0b exp 0", mem_reqValid); end
      tick();
      mem_respValid = 1'b0;
      lsu_reqValid = 1'b0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
      #1;
      checks++; if (mem_reqValid !== 1'b1 || mem_addr !== 32'h600 || mem_wen !== 1'b1 || mem_wmask !== 4'h3 || mem_wdata !== 32'h1) begin errors++; $display("FAIL rc_lsu_issue got %0b/%h/%0b/%h/%h exp 1/00000600/1/3/00000001", mem_reqValid, mem_addr, mem_wen, mem_wmask, mem_wdata); end
      tick();
      mem_respValid = 1'b1;
      #1;
      checks++; if (lsu_respValid !== 1'b1) begin errors++; $display("FAIL rc_lsu_resp got %0b exp 1", lsu_respValid); end
      tick();
      mem_respValid = 1'b0;
      $display("txn response-cycle store 600 issued one cycle later");
   endtask

   task automatic test_reset_mid();
      lsu_reqValid = 1'b1; lsu_addr = 32'h700; lsu_wen = 1'b0;
      tick();
      lsu_reqValid = 1'b0;
      ifu_reqValid = 1'b1; ifu_addr = 32'h800;
      tick();
      ifu_reqValid = 1'b0;
      reset = 1'b1;
      #1;
      checks++; if (mem_reqValid !== 1'b0 || mem_addr !== 32'h0 || mem_wen !== 1'b0 || mem_wdata !== 32'h0 || mem_wmask !== 4'h0) begin errors++; $display("FAIL rst_mid_mem got %0b/%h exp 0/0", mem_reqValid, mem_addr); end
      checks++; if ({ifu_respValid, lsu_respValid} !== 2'b00) begin errors++; $display("FAIL rst_mid_resp got %b exp 00", {ifu_respValid, lsu_respValid}); end
      tick();
      reset = 1'b0;
      #1;
      checks++; if (mem_reqValid !== 1'b0) begin errors++; $display("FAIL rst_slot_dropped got %0b exp 0", mem_reqValid); end
      mem_respValid = 1'b1;
      #1;
      checks++; if ({ifu_respValid, lsu_respValid} !== 2'b00) begin errors++; $display("FAIL rst_late_resp got %b exp 00", {ifu_respValid, lsu_respValid}); end
      tick();
      mem_respValid = 1'b0;
      ifu_reqValid = 1'b1; ifu_addr = 32'h900;
      #1;
      checks++; if (mem_reqValid !== 1'b1 || mem_addr !== 32'h900) begin errors++; $display("FAIL rst_idle_issue got %0b/%h exp 1/00000900", mem_reqValid, mem_addr); end
      tick();
      ifu_reqValid = 1'b0;
      mem_respValid = 1'b1;
      #1;
      checks++; if (ifu_respValid !== 1'b1) begin errors++; $display("FAIL rst_after_resp got %0b exp 1", ifu_respValid); end
      tick();
      mem_respValid = 1'b0;
      $display("txn reset mid-transaction dropped load 700 and fetch 800");
   endtask

   task automatic test_arbitration();
      logic pend_ifu = 1'b0;
      logic pend_lsu = 1'b0;
      logic last_lsu = 1'b0;
      logic exp_lsu;
      logic [AW-1:0] exp_addr;
      for (int g = 0; g < 4; g++) begin
         ifu_reqValid = !pend_ifu; ifu_addr = 32'h1000;
         lsu_reqValid = !pend_lsu; lsu_addr = 32'h2000; lsu_wen = 1'b0;
`ifdef MEM_ARB_RR_EN
         exp_lsu = !last_lsu;
`else
         exp_lsu = 1'b1;
`endif
         exp_addr = exp_lsu ? 32'h2000 : 32'h1000;
         #1;
         checks++; if (mem_reqValid !== 1'b1 || mem_addr !== exp_addr) begin errors++; $display("FAIL arb_grant%0d got %0b/%h exp 1/%h", g, mem_reqValid, mem_addr, exp_addr); end
         last_lsu = exp_lsu;
         pend_lsu = !exp_lsu;
         pend_ifu = exp_lsu;
         tick();
         ifu_reqValid = 1'b0; lsu_reqValid = 1'b0;
         mem_respValid = 1'b1;
         #1;
         checks++; if (lsu_respValid !== exp_lsu || ifu_respValid !== !exp_lsu) begin errors++; $display("FAIL arb_resp%0d got lsu %0b ifu %0b exp %0b %0b", g, lsu_respValid, ifu_respValid, exp_lsu, !exp_lsu); end
         tick();
         mem_respValid = 1'b0;
         $display("txn grant %0d to %s", g, exp_lsu ? "LSU" : "IFU");
      end
      exp_addr = pend_lsu ? 32'h2000 : 32'h1000;
      #1;
      checks++; if (mem_reqValid !== 1'b1 || mem_addr !== exp_addr) begin errors++; $display("FAIL arb_drain got %0b/%h exp 1/%h", mem_reqValid, mem_addr, exp_addr); end
      tick();
      mem_respValid = 1'b1;
      tick();
      mem_respValid = 1'b0;
      $display("txn drained pending %h", exp_addr);
   endtask

   initial begin
      test_reset();
      test_lone_fetch();
      test_simultaneous();
      test_busy();
      test_resp_cycle();
      test_reset_mid();
      test_arbitration();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard stop so the bench can never hang.
   initial begin
      #100000;
      $display("FAIL timeout simulation exceeded time budget");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single SoC memory port (one outstanding transaction) between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Sits between the IFU/LSU io-side handshakes and the memory/bus adapter.
- Requesters issue one-cycle request pulses. The arbiter latches requests that lose arbitration or arrive while busy, issues them one at a time, and routes each response back to its owner only.

Parameters:
- AW, 32, address width.
- DW, 32, data width; mask width is DW/8.

Ports:
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- ifu_reqValid  in  1  one-cycle fetch request pulse
- ifu_addr  in  AW  fetch address, valid with ifu_reqValid
- ifu_respValid  out  1  one-cycle fetch completion pulse
- ifu_rdata  out  DW  fetch data, valid with ifu_respValid
- lsu_reqValid  in  1  one-cycle load/store request pulse
- lsu_addr  in  AW  load/store address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DW  store data
- lsu_wmask  in  DW/8  store byte enables
- lsu_respValid  out  1  one-cycle completion pulse (loads and stores)
- lsu_rdata  out  DW  load data, valid with lsu_respValid
- mem_reqValid  out  1  one-cycle request pulse to memory
- mem_addr  out  AW  request address
- mem_wen  out  1  request is a write
- mem_wdata  out  DW  write data
- mem_wmask  out  DW/8  write byte enables; 0 for reads
- mem_respValid  in  1  memory completion pulse
- mem_rdata  in  DW  memory read data

Behaviour:
- Reset values:
  - state ARB_IDLE.
  - Both pending slots empty.
  - All mem_* outputs and both respValid outputs 0.
  - last_grant = IFU.
- States: ARB_IDLE, ARB_WAIT_IFU, ARB_WAIT_LSU.
- Candidates in ARB_IDLE: pending slot contents, or a live reqValid when that requester's slot is empty.
- Issue, ARB_IDLE with at least one candidate:
  - mem_reqValid = 1 in the same cycle (zero added latency for a live request).
  - mem_addr/wen/wdata/wmask driven from the winner. A live request is bypassed combinationally; a pending one comes from its slot.
  - Next state ARB_WAIT_<winner>. The winner's slot is cleared.
  - The loser's live request is captured into its slot.
- Arbitration: fixed priority, LSU over IFU.
- IFU issues always use mem_wen = 0 and mem_wmask = 0.
- Outside issue cycles, mem_* outputs hold 0.
- ARB_WAIT_x:
  - mem_reqValid = 0.
  - On mem_respValid: x_respValid = 1 for exactly that cycle, then go to ARB_IDLE.
  - The other requester's respValid stays 0.
- ifu_rdata and lsu_rdata are driven combinationally from mem_rdata at all times; only the respValid pulse qualifies them.
- Any reqValid in a cycle where it is not issued is captured into that requester's slot. This includes requests arriving in ARB_WAIT_x and in the response cycle.
- A request arriving in the response cycle is issued in the following ARB_IDLE cycle. This gives a 1-cycle bubble.
- mem_respValid in ARB_IDLE is ignored; no respValid is generated.
- Protocol violations: the first request is kept and the new one is dropped in each case.
  - reqValid while that requester's slot is already full.
  - reqValid while that requester is the current owner.
- Reset mid-transaction:
  - Return to ARB_IDLE and drop the in-flight transaction and both slots.
  - A late mem_respValid after reset deasserts is ignored per the ARB_IDLE rule.
- Maximum outstanding: one at memory plus one pending per requester.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - When both candidates exist, grant the requester that was not last_grant.
  - last_grant updates on every issue.
- Undefined: fixed LSU priority.
  - The last_grant register is not built.
  - An IFU request can wait indefinitely under continuous LSU traffic; accepted in this configuration.

Decomposition:
- Shared package soc_pkg holds:
  - typedef enum arb_state_t {ARB_IDLE, ARB_WAIT_IFU, ARB_WAIT_LSU}.
  - typedef enum logic arb_id_t {ARB_ID_IFU, ARB_ID_LSU}.
- Sub-module arb_req_slot: one pending-request register (valid, addr, wen, wdata, wmask) with capture/clear inputs. Instantiated twice; IFU instance has wen and wmask tied 0.

Test Plan:
- Lone fetch: IFU req addr 0x8000_0000 in IDLE.
  - Expect mem_reqValid same cycle, mem_addr 0x8000_0000, mem_wen 0.
  - Memory responds 3 cycles later with rdata 0x0000_0013.
  - Expect ifu_respValid 1 cycle, ifu_rdata 0x13, lsu_respValid 0.
- Simultaneous requests: IFU 0x100 and LSU store 0x200, wdata 0xDEAD_BEEF, wmask 0xF, same cycle.
  - Expect LSU issued first; lsu_respValid on its response.
  - Expect IFU issued in the next IDLE cycle from its slot with addr 0x100.
- Request while busy: IFU issued; LSU load 0x300 arrives 2 cycles into ARB_WAIT_IFU.
  - Expect no mem_reqValid until IFU response.
  - Expect LSU issued the cycle after the response; lsu_respValid returns mem_rdata 0x1234_5678.
- Response-cycle request: LSU req in the same cycle as mem_respValid for IFU.
  - Expect ifu_respValid that cycle.
  - Expect LSU mem_reqValid exactly one cycle later.
- Reset mid-transaction: assert reset during ARB_WAIT_LSU with IFU pending.
  - Expect all outputs 0 and state ARB_IDLE.
  - A mem_respValid after release produces no respValid.
- MEM_ARB_RR_EN: both requesters present continuously for 4 grants.
  - Expect issue order LSU, IFU, LSU, IFU.
  - Without the macro: LSU issued on every grant while it has requests.
